// File: rtl/tone_sequencer_if.sv
// Note push handshake between the CPU-side I/O logic and the tone sequencer.
// The master offers a note (half-period in us, duration in ms); the slave accepts it when ready.
interface tone_sequencer_if;
    logic        note_valid;
    logic        note_ready;
    logic [15:0] note_half;
    logic [15:0] note_dur;

    modport master (
        output note_valid,
        output note_half,
        output note_dur,
        input  note_ready
    );

    modport slave (
        input  note_valid,
        input  note_half,
        input  note_dur,
        output note_ready
    );
endinterface

// File: rtl/tone_sequencer.sv
// Queued note player feeding the buzzer driver with a half-period in microseconds.
// Notes play back-to-back with exact millisecond timing; output is 0 (silence) when idle.
module tone_sequencer #(
    parameter int DEPTH      = 8,
    parameter int CLK_PER_MS = 50000,
    parameter int GAP_MS     = 0
) (
    input  logic                       clk,
    input  logic                       resetn,
    tone_sequencer_if.slave            note,
    input  logic                       stop,
    output logic [31:0]                num_micros,
    output logic                       busy,
    output logic                       note_done,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int CW   = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    localparam logic [CW-1:0]   CYC_LAST = CW'(CLK_PER_MS - 1);
    localparam logic [15:0]     GAP_LAST = (GAP_MS > 0) ? 16'(GAP_MS - 1) : 16'd0;
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_GAP
    } state_t;

    // Note FIFO: each entry is {half, dur}
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [15:0]     head_half;
    logic [15:0]     head_dur;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cyc_cnt;
    logic [15:0]     ms_cnt;
    logic [15:0]     cur_half;
    logic [15:0]     cur_dur;
    logic            cyc_last;
    logic            note_end;
    logic            gap_end;
    logic            cnt_clr;
    logic            discard_q;
    logic [31:0]     num_nxt;

    assign full            = (count == FULL_CNT);
    assign empty           = (count == '0);
    assign note.note_ready = ~full & ~stop;
    assign push            = note.note_valid & note.note_ready;
    assign {head_half, head_dur} = mem[rd_ptr];
    assign fifo_count      = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {note.note_half, note.note_dur};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (stop) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign cyc_last = (cyc_cnt == CYC_LAST);
    assign note_end = (state == S_PLAY) && cyc_last && (ms_cnt == cur_dur - 16'd1);
    assign gap_end  = (state == S_GAP) && cyc_last && (ms_cnt == GAP_LAST);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a zero-duration head is popped and discarded without leaving IDLE
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        if (stop) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = (head_dur != 16'd0) ? S_PLAY : S_IDLE;
                    end
                end
                S_PLAY: begin
                    if (note_end) begin
                        if (GAP_MS > 0) begin
                            state_nxt = S_GAP;
                        end else if (!empty) begin
                            pop       = 1'b1;
                            state_nxt = (head_dur != 16'd0) ? S_PLAY : S_IDLE;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_end) begin
                        if (!empty) begin
                            pop       = 1'b1;
                            state_nxt = (head_dur != 16'd0) ? S_PLAY : S_IDLE;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs: num_micros is registered from the upcoming state so it tracks the FSM exactly
    always_comb begin
        num_nxt = 32'd0;
        if (state_nxt == S_PLAY) begin
            num_nxt = {16'd0, pop ? head_half : cur_half};
        end
        note_done = (note_end & ~stop) | discard_q;
        busy      = (state != S_IDLE) | ~empty;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            num_micros <= 32'd0;
            discard_q  <= 1'b0;
        end else begin
            num_micros <= num_nxt;
            discard_q  <= pop & (head_dur == 16'd0);
        end
    end

    // Timing counters restart on every pop, state change or abort
    assign cnt_clr = stop | pop | (state_nxt != state);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cyc_cnt <= '0;
            ms_cnt  <= 16'd0;
        end else if (cnt_clr) begin
            cyc_cnt <= '0;
            ms_cnt  <= 16'd0;
        end else if (state != S_IDLE) begin
            if (cyc_last) begin
                cyc_cnt <= '0;
                ms_cnt  <= ms_cnt + 16'd1;
            end else begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            cur_half <= head_half;
            cur_dur  <= head_dur;
        end
    end
endmodule
